// File: rtl/com_cs_mc.sv
// rtl/com_cs_mc.sv - multi-channel com control sequencer
// Round-robin arbitration of NCH send channels onto com_send, plus com_read sequencing.
module com_cs_mc #(
  parameter int NCH       = 4,
  parameter int IW        = 2,
  parameter int BTW       = 4,
  parameter int TOW       = 16,
  parameter int TIMEOUT   = 50000,
  parameter int READ_PRIO = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCH-1:0]     fs_send,
  output logic [NCH-1:0]     fd_send,
  input  logic [NCH*BTW-1:0] send_btype,
  output logic               send_err,
  output logic               fs_com_send,
  input  logic               fd_com_send,
  output logic [BTW-1:0]     com_btype,
  output logic [IW-1:0]      com_idx,
  input  logic               rx_avail,
  output logic               fs_com_read,
  input  logic               fd_com_read,
  input  logic [BTW-1:0]     com_rbtype,
  output logic               fs_read,
  input  logic               fd_read,
  output logic [BTW-1:0]     read_btype
);

  typedef enum logic [2:0] {IDLE, S_REQ, S_ACK, R_REQ, R_FWD, R_REL} state_t;

  localparam logic [TOW-1:0] LP_TO_LAST = TOW'(TIMEOUT - 1);

  state_t         r_state, w_next;
  logic [IW-1:0]  r_rr, r_idx, w_pick;
  logic [TOW-1:0] r_cnt;
  logic           r_err, w_found, w_timeout;
  logic [BTW-1:0] r_btype, r_rbtype;
  logic [NCH-1:0] w_req, w_fd;

  always_comb begin
    w_fd = '0;
    if (r_state == S_ACK) w_fd[r_idx] = 1'b1;
  end

  assign fd_send     = w_fd;
  assign send_err    = (r_state == S_ACK) && r_err;
  assign fs_com_send = (r_state == S_REQ);
  assign fs_com_read = (r_state == R_REQ);
  assign fs_read     = (r_state == R_FWD);
  assign com_idx     = r_idx;
  assign com_btype   = r_btype;
  assign read_btype  = r_rbtype;
  assign w_req       = fs_send & ~w_fd;

  // First requesting channel at or after the rr pointer, wrapping mod NCH.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      int j;
      j = int'(r_rr) + k;
      if (j >= NCH) j = j - NCH;
      if (!w_found && w_req[j]) begin
        w_found = 1'b1;
        w_pick  = IW'(j);
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found && rx_avail) w_next = (READ_PRIO != 0) ? R_REQ : S_REQ;
        else if (w_found)        w_next = S_REQ;
        else if (rx_avail)       w_next = R_REQ;
      end
      S_REQ: begin
        if (fd_com_send) begin
          w_next = S_ACK;
        end else if (TIMEOUT != 0 && r_cnt == LP_TO_LAST) begin
          w_next    = S_ACK;
          w_timeout = 1'b1;
        end
      end
      S_ACK: if (!fs_send[r_idx] && !fd_com_send) w_next = IDLE;
      R_REQ: if (fd_com_read) w_next = R_FWD;
      R_FWD: if (fd_read) w_next = R_REL;
      R_REL: if (!fd_read && !fd_com_read) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr     <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_btype  <= '0;
      r_rbtype <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == S_REQ) begin
        r_idx   <= w_pick;
        r_btype <= send_btype[int'(w_pick)*BTW +: BTW];
        r_err   <= 1'b0;
      end
      if (r_state == S_REQ) begin
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        if (w_next == S_ACK) r_err <= w_timeout;
      end
      if (r_state == S_ACK && w_next == IDLE) begin
        r_rr  <= (int'(r_idx) == NCH - 1) ? '0 : r_idx + 1'b1;
        r_cnt <= '0;
        r_err <= 1'b0;
      end
      if (r_state == R_REQ && fd_com_read) r_rbtype <= com_rbtype;
    end
  end

endmodule

// File: tb/tb_com_cs_mc.sv
// tb/tb_com_cs_mc.sv - directed scoreboard bench for com_cs_mc
module tb_com_cs_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] fs_send, fd_send;
  logic [3:0] tbl [4];
  logic [15:0] send_btype;
  logic       send_err, fs_com_send, fd_com_send;
  logic [3:0] com_btype;
  logic [1:0] com_idx;
  logic       rx_avail, fs_com_read, fd_com_read, fs_read, fd_read;
  logic [3:0] com_rbtype, read_btype;

  logic [3:0] p_fs_send, p_fd_send, p_com_btype, p_read_btype;
  logic       p_send_err, p_fs_com_send, p_rx_avail, p_fs_com_read, p_fs_read;
  logic [1:0] p_com_idx;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;
  assign send_btype = {tbl[3], tbl[2], tbl[1], tbl[0]};

  com_cs_mc #(.NCH(4), .IW(2), .BTW(4), .TOW(16), .TIMEOUT(20), .READ_PRIO(1)) dut (
    .clk(clk), .rst(rst), .fs_send(fs_send), .fd_send(fd_send), .send_btype(send_btype),
    .send_err(send_err), .fs_com_send(fs_com_send), .fd_com_send(fd_com_send),
    .com_btype(com_btype), .com_idx(com_idx), .rx_avail(rx_avail), .fs_com_read(fs_com_read),
    .fd_com_read(fd_com_read), .com_rbtype(com_rbtype), .fs_read(fs_read), .fd_read(fd_read),
    .read_btype(read_btype));

  com_cs_mc #(.NCH(4), .IW(2), .BTW(4), .TOW(16), .TIMEOUT(20), .READ_PRIO(0)) dut_p0 (
    .clk(clk), .rst(rst), .fs_send(p_fs_send), .fd_send(p_fd_send), .send_btype(send_btype),
    .send_err(p_send_err), .fs_com_send(p_fs_com_send), .fd_com_send(1'b0),
    .com_btype(p_com_btype), .com_idx(p_com_idx), .rx_avail(p_rx_avail),
    .fs_com_read(p_fs_com_read), .fd_com_read(1'b0), .com_rbtype(4'h0), .fs_read(p_fs_read),
    .fd_read(1'b0), .read_btype(p_read_btype));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return fs_com_send;
      1: return |fd_send;
      2: return fs_com_read;
      default: return fs_read;
    endcase
  endfunction

  task automatic wait_for(input int which, input logic val, input string tag);
    int n;
    n = 0;
    while (sig(which) !== val && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  // Engine model: pops the expected grant, acks after ack_dly cycles, releases the channel.
  task automatic serve(input int ack_dly, input bit rereq);
    logic [31:0] g;
    wait_for(0, 1'b1, "wait_fs_com_send");
    g = exp_q.pop_front();
    chk("grant_idx", 32'(com_idx), g);
    chk("grant_btype", 32'(com_btype), 32'(tbl[g[1:0]]));
    repeat (ack_dly) @(negedge clk);
    fd_com_send = 1'b1;
    wait_for(1, 1'b1, "wait_fd_send");
    chk("fd_send_onehot", 32'(fd_send), 32'(4'b0001 << g[1:0]));
    chk("send_err_ok", 32'(send_err), 32'd0);
    fs_send[g[1:0]] = 1'b0;
    fd_com_send = 1'b0;
    wait_for(1, 1'b0, "wait_fd_send_low");
    if (rereq) fs_send[g[1:0]] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = 4'h8; tbl[1] = 4'h9; tbl[2] = 4'hA; tbl[3] = 4'h7;
    rst = 1'b1; fs_send = '0; fd_com_send = 0; rx_avail = 0; fd_com_read = 0;
    com_rbtype = '0; fd_read = 0; p_fs_send = '0; p_rx_avail = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {fd_send, send_err, fs_com_send, com_btype, com_idx, fs_com_read,
        fs_read, read_btype}, 32'd0);

    // round robin, all channels held
    fs_send = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int i = 0; i < 5; i++) serve(3, i == 0);
    chk("rr_queue_drained", 32'(exp_q.size()), 32'd0);

    // single send, exact latencies
    fs_send = 4'b0100;
    @(negedge clk);
    chk("s1_fs_com_send", 32'(fs_com_send), 32'd1);
    chk("s1_com_idx", 32'(com_idx), 32'd2);
    chk("s1_com_btype", 32'(com_btype), 32'hA);
    fd_com_send = 1'b1;
    @(negedge clk);
    chk("s1_fd_send", 32'(fd_send), 32'b0100);
    chk("s1_send_err", 32'(send_err), 32'd0);
    chk("s1_fs_com_send_low", 32'(fs_com_send), 32'd0);
    fs_send = '0; fd_com_send = 1'b0;
    @(negedge clk);
    chk("s1_fd_send_low", 32'(fd_send), 32'd0);

    // watchdog timeout
    fs_send = 4'b0010;
    wait_for(0, 1'b1, "to_wait_start");
    n = 0;
    while (fs_com_send && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 32'(n), 32'd20);
    chk("to_fd_send", 32'(fd_send), 32'b0010);
    chk("to_send_err", 32'(send_err), 32'd1);
    fs_send = '0;
    wait_for(1, 1'b0, "to_release");
    chk("to_err_cleared", 32'(send_err), 32'd0);
    fs_send = 4'b0100;
    exp_q.push_back(2);
    serve(2, 1'b0);

    // read path
    exp_q.push_back(5);
    rx_avail = 1'b1;
    @(negedge clk);
    chk("r_fs_com_read", 32'(fs_com_read), 32'd1);
    rx_avail = 1'b0; com_rbtype = 4'h5; fd_com_read = 1'b1;
    @(negedge clk);
    chk("r_fs_read", 32'(fs_read), 32'd1);
    chk("r_fs_com_read_low", 32'(fs_com_read), 32'd0);
    chk("r_read_btype", 32'(read_btype), exp_q.pop_front());
    fd_com_read = 1'b0; com_rbtype = 4'h0;
    repeat (3) @(negedge clk);
    chk("r_btype_held", 32'(read_btype), 32'h5);
    chk("r_fs_read_held", 32'(fs_read), 32'd1);
    fd_read = 1'b1;
    @(negedge clk);
    chk("r_fs_read_drop", 32'(fs_read), 32'd0);
    fd_read = 1'b0;
    @(negedge clk);

    // priority: same-cycle read and send request on both priority settings
    rx_avail = 1'b1; fs_send = 4'b0010;
    p_rx_avail = 1'b1; p_fs_send = 4'b0010;
    @(negedge clk);
    chk("p1_read_first", {fs_com_read, fs_com_send}, 32'b10);
    chk("p0_send_first", {p_fs_com_read, p_fs_com_send}, 32'b01);
    chk("p0_com_idx", 32'(p_com_idx), 32'd1);
    p_rx_avail = 1'b0; p_fs_send = '0;
    rx_avail = 1'b0; fd_com_read = 1'b1; com_rbtype = 4'h3;
    @(negedge clk);
    fd_com_read = 1'b0; fd_read = 1'b1;
    @(negedge clk);
    fd_read = 1'b0;
    exp_q.push_back(1);
    serve(1, 1'b0);

    // reset during S_REQ
    fs_send = 4'b1000;
    wait_for(0, 1'b1, "rs_wait_sreq");
    chk("rs_idx_before", 32'(com_idx), 32'd3);
    rst = 1'b1; fs_send = '0;
    @(negedge clk);
    chk("rs_sreq_outputs", {fd_send, send_err, fs_com_send, com_btype, com_idx}, 32'd0);
    rst = 1'b0;
    fs_send = 4'b0110;
    exp_q.push_back(1); exp_q.push_back(2);
    serve(1, 1'b0);
    serve(1, 1'b0);

    // reset during R_FWD
    rx_avail = 1'b1;
    wait_for(2, 1'b1, "rs_wait_rreq");
    rx_avail = 1'b0; fd_com_read = 1'b1; com_rbtype = 4'h9;
    @(negedge clk);
    chk("rs_in_rfwd", 32'(fs_read), 32'd1);
    rst = 1'b1; fd_com_read = 1'b0; com_rbtype = 4'h0;
    @(negedge clk);
    chk("rs_rfwd_outputs", {fs_read, fs_com_read, read_btype}, 32'd0);
    rst = 1'b0;
    exp_q.push_back(6);
    rx_avail = 1'b1;
    wait_for(2, 1'b1, "rs_fresh_rreq");
    rx_avail = 1'b0; fd_com_read = 1'b1; com_rbtype = 4'h6;
    @(negedge clk);
    chk("rs_fresh_fs_read", 32'(fs_read), 32'd1);
    chk("rs_fresh_btype", 32'(read_btype), exp_q.pop_front());
    fd_com_read = 1'b0; fd_read = 1'b1;
    @(negedge clk);
    fd_read = 1'b0;
    @(negedge clk);
    chk("rs_fresh_done", 32'(fs_read), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
